// File: rtl/shift_reg_ctrl.sv
// Command sequencer for the 8-bit load/rotate/arithmetic-shift register.
// Accepts one command per valid/ready handshake and holds Q between commands by reloading it.
module shift_reg_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] reg_q,
  output logic             reg_pload_n,
  output logic             reg_rotr,
  output logic             reg_asr,
  output logic [WIDTH-1:0] reg_din,
  output logic             reg_clear,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0]       OP_LOAD  = 2'b00;
  localparam logic [1:0]       OP_ROTR  = 2'b01;
  localparam logic [1:0]       OP_ROTL  = 2'b10;
  localparam logic [1:0]       OP_ASR   = 2'b11;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] data_r;
  logic             accept_s;

  assign cmd_ready = (state_r == ST_IDLE) && reset;
  assign accept_s  = cmd_valid && cmd_ready;
  assign busy      = (state_r != ST_IDLE);
  assign done      = (state_r == ST_DONE);
  assign result    = reg_q;

  // State register, step counter and captured command.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      op_r    <= OP_LOAD;
      data_r  <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        op_r   <= cmd_op;
        data_r <= cmd_data;
        cnt_r  <= cmd_steps;
      end else if (state_r == ST_SHIFT) begin
        cnt_r <= cnt_r - CNT_ONE;
      end
    end
  end

  // Next-state logic; leaving SHIFT when the counter reaches one gives exactly N shift edges.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!accept_s) begin
          state_s = ST_IDLE;
        end else if (cmd_op == OP_LOAD) begin
          state_s = ST_LOAD;
        end else if (cmd_steps != CNT_ZERO) begin
          state_s = ST_SHIFT;
        end else begin
          state_s = ST_DONE;
        end
      end
      ST_LOAD:  state_s = ST_DONE;
      ST_SHIFT: begin
        if (cnt_r == CNT_ONE) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_DONE:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Register control; IDLE and DONE recirculate Q because the register has no hold mode.
  always_comb begin
    reg_clear   = 1'b0;
    reg_pload_n = 1'b0;
    reg_din     = reg_q;
    reg_rotr    = 1'b0;
    reg_asr     = 1'b0;
    if (!reset) begin
      reg_clear = 1'b1;
      reg_din   = {WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_LOAD:  reg_din = data_r;
        ST_SHIFT: begin
          reg_pload_n = 1'b1;
          case (op_r)
            OP_ROTR: reg_rotr = 1'b1;
            OP_ROTL: reg_rotr = 1'b0;
            OP_ASR: begin
              reg_rotr = 1'b1;
              reg_asr  = 1'b1;
            end
            default: reg_rotr = 1'b0;
          endcase
        end
        default:  reg_din = reg_q;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Self-checking bench: models the controlled register and checks the sequencer against
// arithmetic expectations of each command's effect and timing.
module tb_shift_reg_ctrl;

  logic       clock;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_steps;
  logic [7:0] cmd_data;
  logic [7:0] reg_q;
  logic       reg_pload_n;
  logic       reg_rotr;
  logic       reg_asr;
  logic [7:0] reg_din;
  logic       reg_clear;
  logic       busy;
  logic       done;
  logic [7:0] result;

  int checks   = 0;
  int failures = 0;

  shift_reg_ctrl #(.WIDTH(8), .CNT_W(3)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_steps(cmd_steps), .cmd_data(cmd_data), .reg_q(reg_q),
    .reg_pload_n(reg_pload_n), .reg_rotr(reg_rotr), .reg_asr(reg_asr),
    .reg_din(reg_din), .reg_clear(reg_clear), .busy(busy), .done(done), .result(result)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // The controlled register (part3) as seen from its pins.
  logic [7:0] q_r;
  always @(posedge clock) begin
    if (reg_clear) q_r <= 8'h00;
    else if (!reg_pload_n) q_r <= reg_din;
    else if (reg_rotr) q_r <= {(reg_asr ? q_r[7] : q_r[0]), q_r[7:1]};
    else q_r <= {q_r[6:0], q_r[7]};
  end
  assign reg_q = q_r;

  // Expected register value after n steps of op, computed arithmetically.
  function automatic logic [7:0] model(input logic [1:0] op, input int n, input logic [7:0] q,
                                       input logic [7:0] d);
    int v;
    int s;
    v = int'(q);
    s = (v >= 128) ? v - 256 : v;
    case (op)
      2'b00:   model = d;
      2'b01:   model = 8'(((v >> n) | (v << (8 - n))) & 255);
      2'b10:   model = 8'(((v << n) | (v >> (8 - n))) & 255);
      default: model = 8'((s >>> n) & 255);
    endcase
  endfunction

  task automatic wait_ready(input string name);
    int budget;
    budget = 0;
    @(negedge clock);
    while (cmd_ready !== 1'b1 && budget < 50) begin
      @(negedge clock);
      budget++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_timeout cmd_ready=%b required=1", name, cmd_ready);
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [2:0] steps, input logic [7:0] data,
                         input string name);
    int lat;
    logic [7:0] q0;
    logic [7:0] exp_q;
    logic [7:0] exp_res;
    wait_ready(name);
    q0 = q_r;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_steps = steps;
    cmd_data  = data;
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_steps = 3'($urandom);
    cmd_data  = 8'($urandom);
    lat     = (op == 2'b00) ? 1 : int'(steps);
    exp_res = model(op, int'(steps), q0, data);
    for (int k = 0; k <= lat + 1; k++) begin
      if (op == 2'b00) exp_q = (k == 0) ? q0 : data;
      else exp_q = model(op, (k < lat) ? k : lat, q0, data);
      checks++;
      if (reg_q !== exp_q) begin
        failures++;
        $display("FAIL %s reg_q k=%0d got=%h required=%h", name, k, reg_q, exp_q);
      end
      checks++;
      if (busy !== (k <= lat)) begin
        failures++;
        $display("FAIL %s busy k=%0d got=%b required=%b", name, k, busy, (k <= lat));
      end
      checks++;
      if (done !== (k == lat)) begin
        failures++;
        $display("FAIL %s done k=%0d got=%b required=%b", name, k, done, (k == lat));
      end
      if (k == lat) begin
        checks++;
        if (result !== exp_res) begin
          failures++;
          $display("FAIL %s result got=%h required=%h", name, result, exp_res);
        end
      end
      if (k == lat + 1) begin
        checks++;
        if (cmd_ready !== 1'b1) begin
          failures++;
          $display("FAIL %s ready_return got=%b required=1", name, cmd_ready);
        end
      end else begin
        @(negedge clock);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (reg_clear !== 1'b1 || reg_pload_n !== 1'b0 || reg_din !== 8'h00 || cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_drive clear=%b pload_n=%b din=%h ready=%b required 1,0,00,0",
               reg_clear, reg_pload_n, reg_din, cmd_ready);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || reg_rotr !== 1'b0 ||
        reg_asr !== 1'b0 || reg_clear !== 1'b0 || result !== 8'h00) begin
      failures++;
      $display("FAIL reset_state ready=%b busy=%b done=%b rotr=%b asr=%b clear=%b result=%h required 1,0,0,0,0,0,00",
               cmd_ready, busy, done, reg_rotr, reg_asr, reg_clear, result);
    end
  endtask

  task automatic test_directed;
    run_cmd(2'b00, 3'd0, 8'hA5, "load_a5");
    run_cmd(2'b01, 3'd3, 8'h00, "rotr3");
    run_cmd(2'b00, 3'd0, 8'h96, "load_96");
    run_cmd(2'b11, 3'd2, 8'h00, "asr2");
    run_cmd(2'b00, 3'd0, 8'h81, "load_81");
    run_cmd(2'b10, 3'd1, 8'h00, "rotl1");
    run_cmd(2'b01, 3'd7, 8'h00, "rotr7");
  endtask

  task automatic test_zero_steps_hold;
    run_cmd(2'b00, 3'd0, 8'h5A, "load_5a");
    run_cmd(2'b11, 3'd0, 8'hFF, "asr0");
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      checks++;
      if (reg_q !== 8'h5A || busy !== 1'b0) begin
        failures++;
        $display("FAIL idle_hold cycle=%0d reg_q=%h busy=%b required 5a,0", i, reg_q, busy);
      end
    end
  endtask

  task automatic test_back_to_back;
    run_cmd(2'b00, 3'd0, 8'h3C, "load_3c");
    wait_ready("b2b");
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_steps = 3'd2;
    cmd_data  = 8'h00;
    @(posedge clock);
    @(negedge clock);
    cmd_op   = 2'b00;
    cmd_data = 8'hFF;
    @(negedge clock);
    checks++;
    if (reg_q !== 8'h1E || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_mid reg_q=%h done=%b required 1e,0", reg_q, done);
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b1 || result !== 8'h0F) begin
      failures++;
      $display("FAIL b2b_first done=%b result=%h required 1,0f", done, result);
    end
    @(negedge clock);
    checks++;
    if (cmd_ready !== 1'b1 || reg_q !== 8'h0F) begin
      failures++;
      $display("FAIL b2b_ready ready=%b reg_q=%h required 1,0f", cmd_ready, reg_q);
    end
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (done !== 1'b1 || result !== 8'hFF) begin
      failures++;
      $display("FAIL b2b_second done=%b result=%h required 1,ff", done, result);
    end
  endtask

  task automatic test_reset_abort;
    int ndone;
    run_cmd(2'b00, 3'd0, 8'h5A, "load_abort");
    wait_ready("abort");
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_steps = 3'd7;
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (reg_q !== 8'h2D) begin
      failures++;
      $display("FAIL abort_pre reg_q=%h required 2d", reg_q);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (reg_clear !== 1'b1 || cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL abort_drive clear=%b ready=%b required 1,0", reg_clear, cmd_ready);
    end
    @(negedge clock);
    checks++;
    if (reg_q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort_edge reg_q=%h busy=%b done=%b required 00,0,0", reg_q, busy, done);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_ready got=%b required=1", cmd_ready);
    end
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (done === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0 || reg_q !== 8'h00) begin
      failures++;
      $display("FAIL abort_nodone pulses=%0d reg_q=%h required 0,00", ndone, reg_q);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 30; i++) begin
      run_cmd(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 8'($urandom), "random");
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_steps = 3'd0;
    cmd_data  = 8'h00;
    test_reset;
    test_directed;
    test_zero_steps_hold;
    test_back_to_back;
    test_reset_abort;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
